// File: rtl/bouncing_sprite_if.sv
// Video bundle between the timing generator and the sprite pixel stage.
// Carries sync/counters in and pipeline-aligned sync/RGB out.
interface bouncing_sprite_if;
    logic        hs_in;
    logic        vs_in;
    logic [10:0] x;
    logic [10:0] y;
    logic        hs_out;
    logic        vs_out;
    logic [1:0]  r;
    logic [1:0]  g;
    logic [1:0]  b;

    modport master (
        output hs_in, vs_in, x, y,
        input  hs_out, vs_out, r, g, b
    );

    modport slave (
        input  hs_in, vs_in, x, y,
        output hs_out, vs_out, r, g, b
    );
endinterface

// File: rtl/bouncing_sprite.sv
// Bouncing sprite pixel stage: 2-cycle pixel pipeline, motion once per frame.
// Optional background grid enabled by defining BOUNCING_SPRITE_GRID_EN.
module bouncing_sprite #(
    parameter int H_ACTIVE = 800,
    parameter int V_ACTIVE = 600,
    parameter int SPR_W    = 64,
    parameter int SPR_H    = 64,
    parameter int STEP     = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       pause,
    output logic [7:0] bounces,
    bouncing_sprite_if.slave vid
);

    localparam logic [11:0] XMAX = 12'(H_ACTIVE - SPR_W);
    localparam logic [11:0] YMAX = 12'(V_ACTIVE - SPR_H);
    localparam logic [11:0] STP  = 12'(STEP);
    localparam logic [11:0] SW   = 12'(SPR_W);
    localparam logic [11:0] SH   = 12'(SPR_H);
    localparam logic [11:0] HA   = 12'(H_ACTIVE);
    localparam logic [11:0] VA   = 12'(V_ACTIVE);

    logic [10:0] pos_x_q, pos_x_d;
    logic [10:0] pos_y_q, pos_y_d;
    logic        dir_x_q, dir_x_d;
    logic        dir_y_q, dir_y_d;
    logic        hit_x, hit_y;
    logic [2:0]  idx_q;
    logic [7:0]  bounces_q;
    logic        vs_prev_q;
    logic        tick;

    logic        act_q, act_d;
    logic        spr_q, spr_d;
    logic        hs1_q, vs1_q;
    logic        grid_q, grid_d;
    logic        hs2_q, vs2_q;
    logic [5:0]  rgb_q, rgb_d;

    // Returns {hit, new_dir, new_pos}; dir 0 = increasing.
    function automatic logic [12:0] move(
        input logic [10:0] p,
        input logic        dir,
        input logic [11:0] lim
    );
        logic [11:0] pw;
        pw = {1'b0, p};
        if (!dir) begin
            if (pw + STP >= lim) move = {1'b1, 1'b1, lim[10:0]};
            else                 move = {1'b0, 1'b0, 11'(pw + STP)};
        end else begin
            if (pw <= STP) move = {1'b1, 1'b0, 11'd0};
            else           move = {1'b0, 1'b1, 11'(pw - STP)};
        end
    endfunction

    assign tick = vid.vs_in & ~vs_prev_q;

    always_comb begin
        {hit_x, dir_x_d, pos_x_d} = move(pos_x_q, dir_x_q, XMAX);
        {hit_y, dir_y_d, pos_y_d} = move(pos_y_q, dir_y_q, YMAX);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pos_x_q   <= '0;
            pos_y_q   <= '0;
            dir_x_q   <= 1'b0;
            dir_y_q   <= 1'b0;
            idx_q     <= '0;
            bounces_q <= '0;
            vs_prev_q <= 1'b0;
        end else begin
            vs_prev_q <= vid.vs_in;
            if (tick && !pause) begin
                pos_x_q <= pos_x_d;
                pos_y_q <= pos_y_d;
                dir_x_q <= dir_x_d;
                dir_y_q <= dir_y_d;
                // A corner hit is a single bounce event
                if (hit_x || hit_y) begin
                    idx_q     <= idx_q + 3'd1;
                    bounces_q <= bounces_q + 8'd1;
                end
            end
        end
    end

    always_comb begin
        act_d = ({1'b0, vid.x} < HA) & ({1'b0, vid.y} < VA);
        spr_d = ({1'b0, vid.x} >= {1'b0, pos_x_q})
              & ({1'b0, vid.x} < {1'b0, pos_x_q} + SW)
              & ({1'b0, vid.y} >= {1'b0, pos_y_q})
              & ({1'b0, vid.y} < {1'b0, pos_y_q} + SH);
`ifdef BOUNCING_SPRITE_GRID_EN
        grid_d = (vid.x[4:0] == 5'd0) | (vid.y[4:0] == 5'd0);
`else
        grid_d = 1'b0;
`endif
    end

    always_comb begin
        rgb_d = 6'b000000;
        if (act_q) begin
            if (spr_q) begin
                rgb_d = {idx_q[0], 1'b1, idx_q[1], 1'b1, idx_q[2], 1'b1};
            end else if (grid_q) begin
                rgb_d = 6'b000001;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            act_q  <= 1'b0;
            spr_q  <= 1'b0;
            grid_q <= 1'b0;
            hs1_q  <= 1'b0;
            vs1_q  <= 1'b0;
            hs2_q  <= 1'b0;
            vs2_q  <= 1'b0;
            rgb_q  <= '0;
        end else begin
            act_q  <= act_d;
            spr_q  <= spr_d;
            grid_q <= grid_d;
            hs1_q  <= vid.hs_in;
            vs1_q  <= vid.vs_in;
            hs2_q  <= hs1_q;
            vs2_q  <= vs1_q;
            rgb_q  <= rgb_d;
        end
    end

    assign vid.hs_out = hs2_q;
    assign vid.vs_out = vs2_q;
    assign vid.r      = rgb_q[5:4];
    assign vid.g      = rgb_q[3:2];
    assign vid.b      = rgb_q[1:0];
    assign bounces    = bounces_q;

endmodule

// File: tb/tb_bouncing_sprite.sv
// Directed bench: three sprite configurations driven in lockstep,
// pixel/sync results checked through a 2-deep expectation queue.
module tb_bouncing_sprite;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n;
    logic       pause;
    logic [7:0] bc0, bc1, bc2;

    bouncing_sprite_if if0 ();
    bouncing_sprite_if if1 ();
    bouncing_sprite_if if2 ();

    bouncing_sprite u0 (
        .clk(clk), .rst_n(rst_n), .pause(pause),
        .bounces(bc0), .vid(if0)
    );
    bouncing_sprite #(.STEP(3)) u1 (
        .clk(clk), .rst_n(rst_n), .pause(pause),
        .bounces(bc1), .vid(if1)
    );
    bouncing_sprite #(.SPR_W(264), .SPR_H(64)) u2 (
        .clk(clk), .rst_n(rst_n), .pause(pause),
        .bounces(bc2), .vid(if2)
    );

    localparam logic [5:0] C0 = 6'b010101;
    localparam logic [5:0] C1 = 6'b110101;
    localparam logic [5:0] C2 = 6'b011101;
    localparam logic [5:0] C3 = 6'b111101;

    typedef struct {
        string      tag;
        logic [5:0] e0, e1, e2;
        logic [1:0] s;
    } exp_t;

    exp_t q[$];
    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input logic [7:0] obs,
                       input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic hs, input logic vs,
                         input logic [10:0] xv, input logic [10:0] yv);
        if0.hs_in = hs; if0.vs_in = vs; if0.x = xv; if0.y = yv;
        if1.hs_in = hs; if1.vs_in = vs; if1.x = xv; if1.y = yv;
        if2.hs_in = hs; if2.vs_in = vs; if2.x = xv; if2.y = yv;
    endtask

    task automatic step(input logic hs, input logic vs,
                        input logic [10:0] xv, input logic [10:0] yv,
                        input logic [5:0] e0, input logic [5:0] e1,
                        input logic [5:0] e2);
        exp_t t;
        @(negedge clk);
        rst_n = 1'b1;
        drive(hs, vs, xv, yv);
        t.tag = $sformatf("px(%0d,%0d,hs%0d,vs%0d)", xv, yv, hs, vs);
        t.e0 = e0; t.e1 = e1; t.e2 = e2; t.s = {hs, vs};
        q.push_back(t);
        @(posedge clk);
        #1;
        if (q.size() > 1) begin
            t = q.pop_front();
            chk({t.tag, "/rgb0"}, {2'b0, if0.r, if0.g, if0.b}, {2'b0, t.e0});
            chk({t.tag, "/rgb1"}, {2'b0, if1.r, if1.g, if1.b}, {2'b0, t.e1});
            chk({t.tag, "/rgb2"}, {2'b0, if2.r, if2.g, if2.b}, {2'b0, t.e2});
            chk({t.tag, "/sync0"}, {6'b0, if0.hs_out, if0.vs_out}, {6'b0, t.s});
            chk({t.tag, "/sync1"}, {6'b0, if1.hs_out, if1.vs_out}, {6'b0, t.s});
            chk({t.tag, "/sync2"}, {6'b0, if2.hs_out, if2.vs_out}, {6'b0, t.s});
        end
    endtask

    task automatic rstep(input int n);
        @(negedge clk);
        rst_n = 1'b0;
        drive(1'b1, 1'b0, 11'd100, 11'd0);
        q.delete();
        @(posedge clk);
        #1;
        chk($sformatf("rst%0d/out0", n),
            {if0.hs_out, if0.vs_out, if0.r, if0.g, if0.b}, 8'h00);
        chk($sformatf("rst%0d/out1", n),
            {if1.hs_out, if1.vs_out, if1.r, if1.g, if1.b}, 8'h00);
        chk($sformatf("rst%0d/out2", n),
            {if2.hs_out, if2.vs_out, if2.r, if2.g, if2.b}, 8'h00);
        chk($sformatf("rst%0d/bounces0", n), bc0, 8'd0);
    endtask

    task automatic probe(input logic [10:0] xv, input logic [10:0] yv,
                         input logic [5:0] e0, input logic [5:0] e1,
                         input logic [5:0] e2);
        step(1'b0, 1'b0, xv, yv, e0, e1, e2);
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) begin
            step(1'b0, 1'b1, 11'd0, 11'd700, 6'd0, 6'd0, 6'd0);
            step(1'b0, 1'b0, 11'd0, 11'd700, 6'd0, 6'd0, 6'd0);
        end
    endtask

    task automatic bchk(input string tag, input logic [7:0] a,
                        input logic [7:0] b, input logic [7:0] c);
        chk({tag, "/bounces0"}, bc0, a);
        chk({tag, "/bounces1"}, bc1, b);
        chk({tag, "/bounces2"}, bc2, c);
    endtask

    initial begin
        rst_n = 1'b0;
        pause = 1'b0;
        drive(1'b0, 1'b0, 11'd100, 11'd0);

        for (int i = 0; i < 3; i++) rstep(i);

        probe(11'd0, 11'd0, C0, C0, C0);
        probe(11'd100, 11'd100, 6'd0, 6'd0, 6'd0);

        // hsync pulse of width 3 then idle
        for (int i = 0; i < 3; i++)
            step(1'b1, 1'b0, 11'd0, 11'd700, 6'd0, 6'd0, 6'd0);
        for (int i = 0; i < 2; i++)
            step(1'b0, 1'b0, 11'd0, 11'd700, 6'd0, 6'd0, 6'd0);

        // vsync pulse of width 2: frame tick 1
        for (int i = 0; i < 2; i++)
            step(1'b0, 1'b1, 11'd0, 11'd700, 6'd0, 6'd0, 6'd0);
        step(1'b0, 1'b0, 11'd0, 11'd700, 6'd0, 6'd0, 6'd0);

        probe(11'd2, 11'd2, C0, 6'd0, C0);
        probe(11'd1, 11'd2, 6'd0, 6'd0, 6'd0);
        probe(11'd3, 11'd3, C0, C0, C0);

        pause = 1'b1;
        ticks(5);
        probe(11'd65, 11'd2, C0, 6'd0, C0);
        probe(11'd66, 11'd2, 6'd0, 6'd0, C0);
        probe(11'd2, 11'd65, C0, 6'd0, C0);
        probe(11'd2, 11'd66, 6'd0, 6'd0, 6'd0);
        bchk("pause", 8'd0, 8'd0, 8'd0);
        pause = 1'b0;

        ticks(1);
        probe(11'd3, 11'd4, 6'd0, 6'd0, 6'd0);
        probe(11'd4, 11'd4, C0, 6'd0, C0);
        probe(11'd6, 11'd6, C0, C0, C0);

        ticks(244);
        probe(11'd736, 11'd335, 6'd0, C2, 6'd0);
        probe(11'd735, 11'd335, 6'd0, 6'd0, 6'd0);
        bchk("tick246", 8'd0, 8'd2, 8'd0);

        ticks(22);
        probe(11'd536, 11'd536, C1, 6'd0, C1);
        probe(11'd535, 11'd536, 6'd0, 6'd0, 6'd0);
        probe(11'd670, 11'd269, 6'd0, C2, 6'd0);
        probe(11'd669, 11'd269, 6'd0, 6'd0, 6'd0);
        bchk("tick268", 8'd1, 8'd2, 8'd1);

        ticks(100);
        probe(11'd736, 11'd336, C2, 6'd0, 6'd0);
        probe(11'd735, 11'd336, 6'd0, 6'd0, 6'd0);
        probe(11'd799, 11'd336, C2, 6'd0, 6'd0);
        probe(11'd800, 11'd336, 6'd0, 6'd0, 6'd0);
        probe(11'd336, 11'd336, 6'd0, 6'd0, C1);
        probe(11'd335, 11'd336, 6'd0, 6'd0, 6'd0);
        probe(11'd370, 11'd30, 6'd0, C3, 6'd0);
        probe(11'd369, 11'd30, 6'd0, 6'd0, 6'd0);
        step(1'b0, 1'b0, 11'd0, 11'd700, 6'd0, 6'd0, 6'd0);
        bchk("tick368", 8'd2, 8'd3, 8'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
